// File: rtl/stream_demux_1x4.sv
// -----------------------------------------------------------------------------
// stream_demux_1x4
//
// Registered 1-to-4 stream demultiplexer. One valid/ready input stream is
// routed to one of four output channels. Each channel owns a one-entry holding
// register. The destination is either the explicit select (in_sel) or an
// internal round-robin pointer (in_rr = 1).
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : input beat (WIDTH bits)
//   in_sel     : destination channel when in_rr = 0
//   in_rr      : 1 = round-robin routing, in_sel ignored
//   in_valid   : producer offers a beat
//   in_ready   : block accepts a beat this cycle (combinational)
//   out_data   : channel i data at [i*WIDTH +: WIDTH]
//   out_valid  : channel i holds a beat
//   out_ready  : consumer i takes its beat
//   rr_ptr     : next round-robin destination
//   acc_cnt    : accepted-beat counter, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module stream_demux_1x4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_rr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [1:0]           rr_ptr,
    output logic [CNT_W-1:0]     acc_cnt
);

    localparam int N_CH = 4;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] buf_r [N_CH];
    logic [3:0]       full_r;
    logic [1:0]       rr_ptr_r;
    logic [CNT_W-1:0] acc_cnt_r;

    logic [1:0]       tgt_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [3:0]       wr_s;
    logic [3:0]       drain_s;

    // Target selection, ready generation and per-channel write/drain strobes.
    always_comb begin
        tgt_s      = 2'd0;
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        wr_s       = 4'b0000;
        drain_s    = 4'b0000;

        if (in_rr) begin
            tgt_s = rr_ptr_r;
        end else begin
            tgt_s = in_sel;
        end

        // A full target can still take a beat when its consumer drains it
        // in the same cycle, which keeps one beat per cycle into a busy channel.
        in_ready_s = ~full_r[tgt_s] | out_ready[tgt_s];
        accept_s   = in_valid & in_ready_s;

        if (accept_s) begin
            wr_s = 4'b0001 << tgt_s;
        end else begin
            wr_s = 4'b0000;
        end

        drain_s = full_r & out_ready;
    end

    // Occupancy flags: a write wins over a drain on the same channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 4'b0000;
        end else begin
            full_r <= (full_r & ~drain_s) | wr_s;
        end
    end

    // Holding registers: change only when written, never on a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                buf_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr_s[i]) begin
                    buf_r[i] <= in_data;
                end else begin
                    buf_r[i] <= buf_r[i];
                end
            end
        end
    end

    // Round-robin pointer advances only on beats routed by it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= 2'd0;
        end else if (accept_s && in_rr) begin
            rr_ptr_r <= rr_ptr_r + 2'd1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Accepted-beat counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            acc_cnt_r <= acc_cnt_r + CNT_ONE;
        end else begin
            acc_cnt_r <= acc_cnt_r;
        end
    end

    // Pack the holding registers onto the flat output bus.
    always_comb begin
        out_data = {(4*WIDTH){1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            out_data[i*WIDTH +: WIDTH] = buf_r[i];
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = full_r;
    assign rr_ptr    = rr_ptr_r;
    assign acc_cnt   = acc_cnt_r;

endmodule

// File: tb/tb_stream_demux_1x4.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1x4
//
// Self-checking bench for stream_demux_1x4. The reference model is a set of
// four per-channel queues (a channel is "full" when its queue holds a beat),
// plus a round-robin index and a beat count. Directed scenarios are followed
// by randomized traffic and a counter-wrap run.
// -----------------------------------------------------------------------------
module tb_stream_demux_1x4;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_rr;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [1:0]         rr_ptr;
    logic [CNT_W-1:0]   acc_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [WIDTH-1:0] sb [4][$];
    int               m_rr;
    int               m_cnt;

    stream_demux_1x4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_rr     (in_rr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .acc_cnt   (acc_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) sb[i].delete();
        m_rr  = 0;
        m_cnt = 0;
    endtask

    // Compare registered outputs against the model.
    task automatic check_outputs();
        logic [3:0] ev;
        ev = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ev[i] = (sb[i].size() != 0);
            if (sb[i].size() != 0)
                check($sformatf("data%0d", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'(sb[i][0]));
        end
        check("out_valid", 32'(out_valid), 32'(ev));
        check("rr_ptr", 32'(rr_ptr), 32'(m_rr));
        check("acc_cnt", 32'(acc_cnt), 32'(m_cnt % 256));
    endtask

    // One clock cycle: drive, check in_ready and drained beats, clock, check state.
    task automatic step(input logic [WIDTH-1:0] d, input logic [1:0] sel, input logic rr,
                        input logic v, input logic [3:0] ordy, output logic acc);
        int  tgt;
        bit  exp_rdy;
        logic [WIDTH-1:0] got;
        in_data   = d;
        in_sel    = sel;
        in_rr     = rr;
        in_valid  = v;
        out_ready = ordy;
        #1;
        tgt     = rr ? m_rr : int'(sel);
        exp_rdy = (sb[tgt].size() == 0) || ordy[tgt];
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        // Consumers take the beats they are offered; each must match the scoreboard.
        for (int i = 0; i < 4; i++) begin
            if (sb[i].size() != 0 && ordy[i]) begin
                got = out_data[i*WIDTH +: WIDTH];
                check($sformatf("drain%0d", i), 32'(got), 32'(sb[i].pop_front()));
            end
        end
        acc = v && exp_rdy;
        if (acc) begin
            sb[tgt].push_back(d);
            m_cnt++;
            if (rr) m_rr = (m_rr + 1) % 4;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        in_data   = '0;
        in_sel    = 2'd0;
        in_rr     = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_rr", 32'(rr_ptr), 32'd0);
        check("rst_cnt", 32'(acc_cnt), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       acc;
        logic [3:0] d;
        logic [1:0] sel;
        logic       rr;
        logic       v;
        logic       pend;
        int         n;
        int         guard;
        int         dest [6];

        rst_n = 1'b0;
        model_reset();
        do_reset();

        // Single fixed-select beat into channel 2, no consumers ready.
        step(4'hA, 2'd2, 1'b0, 1'b1, 4'b0000, acc);
        check("t1_valid", 32'(out_valid), 32'h4);
        check("t1_data2", 32'(out_data[11:8]), 32'hA);
        check("t1_cnt", 32'(acc_cnt), 32'd1);
        check("t1_rr", 32'(rr_ptr), 32'd0);
        step(4'h0, 2'd2, 1'b0, 1'b0, 4'b0000, acc);   // in_ready expected 0
        step(4'h0, 2'd0, 1'b0, 1'b0, 4'b0000, acc);   // in_ready expected 1

        // Backpressure on channel 1, then a same-cycle drain and refill.
        step(4'h5, 2'd1, 1'b0, 1'b1, 4'b0000, acc);
        for (int k = 0; k < 3; k++) begin
            step(4'h7, 2'd1, 1'b0, 1'b1, 4'b0000, acc);
            check("bp_stall", 32'(acc), 32'd0);
            check("bp_data1", 32'(out_data[7:4]), 32'h5);
        end
        step(4'h7, 2'd1, 1'b0, 1'b1, 4'b0010, acc);
        check("bp_data1_new", 32'(out_data[7:4]), 32'h7);
        check("bp_valid1", 32'(out_valid[1]), 32'd1);
        check("bp_cnt", 32'(acc_cnt), 32'd3);

        // Round-robin, six back-to-back beats with all consumers ready.
        do_reset();
        dest = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 6; k++) begin
            step(WIDTH'(k + 1), 2'd3, 1'b1, 1'b1, 4'b1111, acc);
            check("rr_dest", 32'(out_data[dest[k]*WIDTH +: WIDTH]), 32'(k + 1));
        end
        check("rr_ptr_end", 32'(rr_ptr), 32'd2);
        check("rr_cnt_end", 32'(acc_cnt), 32'd6);

        // Mode switch: RR beat, two fixed beats to channel 3, back to RR.
        do_reset();
        step(4'h1, 2'd0, 1'b1, 1'b1, 4'b0000, acc);
        step(4'h2, 2'd3, 1'b0, 1'b1, 4'b1000, acc);
        check("ms_fix1", 32'(out_data[15:12]), 32'h2);
        step(4'h3, 2'd3, 1'b0, 1'b1, 4'b1000, acc);
        check("ms_fix2", 32'(out_data[15:12]), 32'h3);
        check("ms_rr_hold", 32'(rr_ptr), 32'd1);
        step(4'h9, 2'd0, 1'b1, 1'b1, 4'b0000, acc);
        check("ms_rr_ch1", 32'(out_data[7:4]), 32'h9);
        check("ms_valid", 32'(out_valid), 32'b1011);

        // Asynchronous reset in the middle of a cycle with three channels full.
        do_reset();
        for (int k = 0; k < 3; k++) step(WIDTH'(k + 12), 2'd0, 1'b1, 1'b1, 4'b0000, acc);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_data", 32'(out_data), 32'd0);
        check("mr_cnt", 32'(acc_cnt), 32'd0);
        check("mr_rr", 32'(rr_ptr), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Randomized traffic; a stalled beat is held stable until accepted.
        pend = 1'b0;
        d = 4'h0; sel = 2'd0; rr = 1'b0; v = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!pend) begin
                d   = 4'($urandom);
                sel = 2'($urandom);
                rr  = 1'($urandom);
                v   = ($urandom_range(0, 3) != 0);
            end
            step(d, sel, rr, v, 4'($urandom), acc);
            pend = v && !acc;
        end

        // Counter wrap: 257 accepted beats with every consumer ready.
        do_reset();
        n     = 0;
        guard = 0;
        while (n < 257 && guard < 1000) begin
            step(4'($urandom), 2'($urandom), 1'($urandom), 1'b1, 4'b1111, acc);
            if (acc) n++;
            guard++;
        end
        check("wrap_beats", 32'(n), 32'd257);
        check("wrap_cnt", 32'(acc_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
